display_bcd_scan: RTL and testbench

DISPLAY_BCD_SCAN -- requirements
Module: display_bcd_scan

---
 rtl/display_bcd_scan.sv | 182 ++++++++++++++++++
 tb/tb_display_bcd_scan.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_bcd_scan.sv
// display_bcd_scan
//   Converts an unsigned binary word to NDIG decimal digits using sequential
//   shift-and-add-3 (double dabble), one input bit per clock, MSB first. It
//   then time-multiplexes the committed digits onto a common-segment
//   7-segment display.
//
// Ports
//   clkm     : system clock; all state changes on its rising edge
//   rst      : asynchronous active-high reset
//   dato     : [DATA_W-1:0] unsigned value to display
//   load     : one-cycle strobe; dato is accepted only while busy=0
//   busy     : conversion in progress (CONV or COMMIT)
//   done     : one-cycle pulse on the edge that commits new digits
//   overflow : committed value exceeds 10^NDIG-1 (all positions show "-")
//   an       : [NDIG-1:0] one-hot digit enable, an[0] = units
//   seg      : [7:0] segments {dp,g,f,e,d,c,b,a}; dp is never lit
module display_bcd_scan #(
   parameter int DATA_W     = 10,
   parameter int NDIG       = 4,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_LZ   = 1,
   parameter int ACTIVE_LOW = 1
) (
   input  logic              clkm,
   input  logic              rst,
   input  logic [DATA_W-1:0] dato,
   input  logic              load,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [NDIG-1:0]   an,
   output logic [7:0]        seg
);

   localparam int unsigned NBCD = NDIG + 1;          // display digits + guard digit
   localparam int          BW   = 4 * NDIG + 4;
   localparam int          CW   = $clog2(DATA_W + 1);
   localparam int          PW   = $clog2(SCAN_DIV);
   localparam int          IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CONV   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]        state;
   logic [DATA_W-1:0] sr;
   logic [BW-1:0]     bcd;
   logic [BW-1:0]     adj;
   logic [BW-1:0]     bcd_next;
   logic              carry_out;
   logic              lost;
   logic [CW-1:0]     bit_cnt;
   logic [4*NDIG-1:0] digits;
   logic              ovf_q;

   logic [PW-1:0]     presc;
   logic [IW-1:0]     idx;
   logic [NDIG-1:0]   an_raw;
   logic [7:0]        seg_raw;
   logic [3:0]        cur_digit;
   logic              higher_nz;

   // One double-dabble step: add 3 to every digit >= 5, then shift in next bit.
   always_comb begin
      adj = bcd;
      for (int unsigned k = 0; k < NBCD; k++) begin
         if (adj[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
         end
      end
      bcd_next  = {adj[BW-2:0], sr[DATA_W-1]};
      carry_out = adj[BW-1];
   end

   // Wide inputs with few digits can push a bit out of the guard digit. Such
   // a bit is remembered so that these cases are still flagged as overflow.
   always_ff @(posedge clkm or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         sr      <= '0;
         bcd     <= '0;
         lost    <= 1'b0;
         bit_cnt <= '0;
         digits  <= '0;
         ovf_q   <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (load) begin
                  sr      <= dato;
                  bcd     <= '0;
                  lost    <= 1'b0;
                  bit_cnt <= '0;
                  state   <= S_CONV;
               end
            end
            S_CONV: begin
               sr      <= {sr[DATA_W-2:0], 1'b0};
               bcd     <= bcd_next;
               lost    <= lost | carry_out;
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == CW'(DATA_W - 1)) begin
                  state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               digits <= bcd[4*NDIG-1:0];
               ovf_q  <= lost || (bcd[BW-1 -: 4] != 4'd0);
               done   <= 1'b1;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy     = (state != S_IDLE);
   assign overflow = ovf_q;

   // Scan prescaler and digit index
   always_ff @(posedge clkm or posedge rst) begin
      if (rst) begin
         presc <= '0;
         idx   <= '0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // higher_nz covers the current digit and every digit above it. A zero
   // digit is blanked only when that whole span is zero.
   always_comb begin
      cur_digit = '0;
      higher_nz = 1'b0;
      an_raw    = '0;
      for (int unsigned k = 0; k < NDIG; k++) begin
         if (IW'(k) == idx) begin
            cur_digit = digits[4*k +: 4];
            an_raw[k] = 1'b1;
         end
         if ((IW'(k) >= idx) && (digits[4*k +: 4] != 4'd0)) begin
            higher_nz = 1'b1;
         end
      end
      if (ovf_q) begin
         seg_raw = 8'h40;
      end else if ((BLANK_LZ != 0) && (idx != '0) && !higher_nz) begin
         seg_raw = 8'h00;
      end else begin
         case (cur_digit)
            4'd0:    seg_raw = 8'h3F;
            4'd1:    seg_raw = 8'h06;
            4'd2:    seg_raw = 8'h5B;
            4'd3:    seg_raw = 8'h4F;
            4'd4:    seg_raw = 8'h66;
            4'd5:    seg_raw = 8'h6D;
            4'd6:    seg_raw = 8'h7D;
            4'd7:    seg_raw = 8'h07;
            4'd8:    seg_raw = 8'h7F;
            4'd9:    seg_raw = 8'h6F;
            default: seg_raw = 8'h00;
         endcase
      end
   end

   // Output registers; the polarity is applied only here.
   always_ff @(posedge clkm or posedge rst) begin
      if (rst) begin
         an  <= (ACTIVE_LOW != 0) ? '1 : '0;
         seg <= (ACTIVE_LOW != 0) ? '1 : '0;
      end else begin
         an  <= (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;
         seg <= (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      end
   end

endmodule

// File: tb/tb_display_bcd_scan.sv
// tb_display_bcd_scan
//   Three instances with different parameter sets share one clock and one
//   reset. A behavioural model predicts busy/done/overflow/an/seg every
//   cycle from decimal arithmetic. Directed loads and literal expectations
//   exercise latency, blanking, overflow, ignored loads and reset abort.
`timescale 1ns/1ps
module tb_display_bcd_scan;

   localparam int NI = 3;

   logic clkm = 1'b0;
   logic rst;
   always #5 clkm = ~clkm;

   int total = 0;
   int bad   = 0;

   int dw [NI] = '{10, 10, 14};
   int nd [NI] = '{4, 3, 4};
   int sd [NI] = '{4, 3, 2};
   int bl [NI] = '{1, 1, 0};
   int al [NI] = '{1, 1, 0};

   logic        load_v [NI];
   logic [19:0] dato_v [NI];

   logic       busy0, busy1, busy2, done0, done1, done2, ovf0, ovf1, ovf2;
   logic [3:0] an0, an2;
   logic [2:0] an1;
   logic [7:0] seg0, seg1, seg2;

   display_bcd_scan #(.DATA_W(10), .NDIG(4), .SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(1)) u0 (
      .clkm(clkm), .rst(rst), .dato(dato_v[0][9:0]), .load(load_v[0]),
      .busy(busy0), .done(done0), .overflow(ovf0), .an(an0), .seg(seg0));

   display_bcd_scan #(.DATA_W(10), .NDIG(3), .SCAN_DIV(3)) u1 (
      .clkm(clkm), .rst(rst), .dato(dato_v[1][9:0]), .load(load_v[1]),
      .busy(busy1), .done(done1), .overflow(ovf1), .an(an1), .seg(seg1));

   display_bcd_scan #(.DATA_W(14), .NDIG(4), .SCAN_DIV(2), .BLANK_LZ(0), .ACTIVE_LOW(0)) u2 (
      .clkm(clkm), .rst(rst), .dato(dato_v[2][13:0]), .load(load_v[2]),
      .busy(busy2), .done(done2), .overflow(ovf2), .an(an2), .seg(seg2));

   logic       busy_v [NI];
   logic       done_v [NI];
   logic       ovf_v  [NI];
   logic [5:0] an_v   [NI];
   logic [7:0] seg_v  [NI];

   assign busy_v[0] = busy0;  assign busy_v[1] = busy1;  assign busy_v[2] = busy2;
   assign done_v[0] = done0;  assign done_v[1] = done1;  assign done_v[2] = done2;
   assign ovf_v[0]  = ovf0;   assign ovf_v[1]  = ovf1;   assign ovf_v[2]  = ovf2;
   assign an_v[0]   = {2'b00, an0};
   assign an_v[1]   = {3'b000, an1};
   assign an_v[2]   = {2'b00, an2};
   assign seg_v[0]  = seg0;   assign seg_v[1]  = seg1;   assign seg_v[2]  = seg2;

   function automatic int pow10(input int n);
      int r = 1;
      for (int j = 0; j < n; j++) r = r * 10;
      return r;
   endfunction

   function automatic logic [7:0] seg7(input int d);
      case (d)
         0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
         4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
         8: return 8'h7F;  9: return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string name, input int i, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[u%0d] got=%0h want=%0h t=%0t", name, i, act, exp, $time);
      end
   endtask

   // Behavioural model: timer counts down from DATA_W+1 after an accepted
   // load; the display is a decimal view of the last committed value.
   int         m_timer [NI];
   int         m_pend  [NI];
   int         m_val   [NI];
   int         m_cyc   [NI];
   logic       m_ovf   [NI];
   logic       m_done  [NI];
   logic [5:0] e_an    [NI];
   logic [7:0] e_seg   [NI];

   always @(posedge clkm or posedge rst) begin
      for (int i = 0; i < NI; i++) begin
         int mask;
         int pos;
         logic [7:0] s;
         logic [5:0] a;
         mask = (1 << nd[i]) - 1;
         if (rst) begin
            m_timer[i] <= 0;
            m_pend[i]  <= 0;
            m_val[i]   <= 0;
            m_cyc[i]   <= 0;
            m_ovf[i]   <= 1'b0;
            m_done[i]  <= 1'b0;
            e_an[i]    <= (al[i] != 0) ? 6'(mask) : 6'd0;
            e_seg[i]   <= (al[i] != 0) ? 8'hFF : 8'h00;
         end else begin
            pos = (m_cyc[i] / sd[i]) % nd[i];
            if (m_ovf[i])
               s = 8'h40;
            else if (bl[i] != 0 && pos != 0 && m_val[i] < pow10(pos))
               s = 8'h00;
            else
               s = seg7((m_val[i] / pow10(pos)) % 10);
            a = 6'(1 << pos);
            e_an[i]  <= (al[i] != 0) ? (~a & 6'(mask)) : a;
            e_seg[i] <= (al[i] != 0) ? ~s : s;
            m_cyc[i]  <= m_cyc[i] + 1;
            m_done[i] <= (m_timer[i] == 1);
            if (m_timer[i] == 0) begin
               if (load_v[i]) begin
                  m_timer[i] <= dw[i] + 1;
                  m_pend[i]  <= int'(dato_v[i]);
               end
            end else begin
               m_timer[i] <= m_timer[i] - 1;
               if (m_timer[i] == 1) begin
                  m_val[i] <= m_pend[i];
                  m_ovf[i] <= (m_pend[i] > pow10(nd[i]) - 1);
               end
            end
         end
      end
   end

   always @(negedge clkm) begin
      for (int i = 0; i < NI; i++) begin
         chk("busy", i, busy_v[i], (m_timer[i] != 0));
         chk("done", i, done_v[i], m_done[i]);
         chk("overflow", i, ovf_v[i], m_ovf[i]);
         chk("an", i, an_v[i], e_an[i]);
         chk("seg", i, seg_v[i], e_seg[i]);
      end
   end

   // Stimulus runs at posedge+2 so inputs are stable at every active edge.
   task automatic do_load(input int i, input int v);
      load_v[i] = 1'b1;
      dato_v[i] = 20'(v);
      @(posedge clkm); #2;
      load_v[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, output int n);
      n = -1;
      for (int c = 1; c <= 64; c++) begin
         @(posedge clkm); #2;
         if (done_v[i]) begin
            n = c;
            break;
         end
      end
   endtask

   task automatic wait_an(input int i, input logic [5:0] a);
      bit ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (an_v[i] == a) begin
            ok = 1'b1;
            break;
         end
         @(posedge clkm); #2;
      end
      if (!ok) chk("wait_an_timeout", i, 0, 1);
   endtask

   initial begin
      int n;
      int cnt;
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         load_v[i] = 1'b0;
         dato_v[i] = '0;
      end
      repeat (3) @(posedge clkm);
      #2 rst = 1'b0;

      // First edge after reset: position 0 showing "0", held SCAN_DIV cycles
      @(posedge clkm); #2;
      chk("lit_rst_an", 0, an0, 4'hE);
      chk("lit_rst_seg", 0, seg0, 8'hC0);
      n = 1;
      for (int c = 0; c < 20; c++) begin
         @(posedge clkm); #2;
         if (an0 == 4'hE) n++;
         else break;
      end
      chk("lit_hold_pos0", 0, n, 4);
      chk("lit_next_pos1", 0, an0, 4'hD);

      // 166: latency, blanked position 3
      do_load(0, 166);
      chk("lit_busy_rise", 0, busy0, 1);
      wait_done(0, n);
      chk("lit_latency", 0, n, 11);
      wait_an(0, 6'h0D);  chk("lit_166_pos1", 0, seg0, 8'h82);
      wait_an(0, 6'h0B);  chk("lit_166_pos2", 0, seg0, 8'hF9);
      wait_an(0, 6'h07);  chk("lit_166_pos3", 0, seg0, 8'hFF);

      // Load while busy is dropped
      do_load(0, 238);
      @(posedge clkm); #2;
      do_load(0, 500);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clkm); #2;
         if (done0) cnt++;
      end
      chk("lit_one_done", 0, cnt, 1);
      wait_an(0, 6'h0D);  chk("lit_238_pos1", 0, seg0, 8'hB0);

      // Reset mid-conversion
      do_load(0, 321);
      repeat (5) begin @(posedge clkm); #2; end
      rst = 1'b1;
      #1;
      chk("lit_abort_busy", 0, busy0, 0);
      chk("lit_abort_an", 0, an0, 4'hF);
      @(posedge clkm); #2 rst = 1'b0;
      @(posedge clkm); #2;
      chk("lit_post_rst_an", 0, an0, 4'hE);
      chk("lit_post_rst_seg", 0, seg0, 8'hC0);
      do_load(0, 45);
      wait_done(0, n);
      chk("lit_latency2", 0, n, 11);
      wait_an(0, 6'h0D);  chk("lit_45_pos1", 0, seg0, 8'h99);

      // NDIG=3 overflow then recovery
      do_load(1, 1023);
      wait_done(1, n);
      chk("lit_ovf_set", 1, ovf1, 1);
      wait_an(1, 6'h06);  chk("lit_ovf_dash", 1, seg1, 8'hBF);
      do_load(1, 999);
      wait_done(1, n);
      chk("lit_ovf_clr", 1, ovf1, 0);
      wait_an(1, 6'h03);  chk("lit_999_pos2", 1, seg1, 8'h90);

      // No blanking, active-high outputs, 14-bit input boundaries
      do_load(2, 7);
      wait_done(2, n);
      chk("lit_latency14", 2, n, 15);
      wait_an(2, 6'h08);  chk("lit_7_pos3", 2, seg2, 8'h3F);
      wait_an(2, 6'h01);  chk("lit_7_pos0", 2, seg2, 8'h07);
      do_load(2, 0);
      wait_done(2, n);
      wait_an(2, 6'h04);  chk("lit_0_pos2", 2, seg2, 8'h3F);
      do_load(2, 9999);
      wait_done(2, n);
      chk("lit_9999_ovf", 2, ovf2, 0);
      wait_an(2, 6'h08);  chk("lit_9999_pos3", 2, seg2, 8'h6F);
      do_load(2, 10000);
      wait_done(2, n);
      chk("lit_10000_ovf", 2, ovf2, 1);
      wait_an(2, 6'h01);  chk("lit_10000_dash", 2, seg2, 8'h40);

      repeat (10) @(posedge clkm);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
